// File: rtl/a_fifo_pkg.sv
// a_fifo_pkg: shared defaults for the single-clock FIFO.
//   DATA_WIDTH - width of one stored word
//   FIFO_DEPTH - number of storage entries (power of two)
//   ADDR_SIZE  - pointer width, log2(FIFO_DEPTH)+1; the extra MSB is the wrap bit
//   MEM_AW     - memory index width (pointer width without the wrap bit)
package a_fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned ADDR_SIZE  = 5;
  localparam int unsigned MEM_AW     = ADDR_SIZE - 1;

endpackage

// File: rtl/a_fifo_mem.sv
// a_fifo_mem: simple dual-port RAM, synchronous write, registered read port.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset; clears only the read register
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   re    - read enable; rdata loads ram[raddr] on the edge, else holds
//   raddr - read index
//   rdata - registered read data
module a_fifo_mem
  import a_fifo_pkg::*;
#(
  parameter int unsigned DW    = DATA_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = MEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] ram [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= ram[raddr];
    end
  end

endmodule

// File: rtl/a_fifo.sv
// a_fifo: single-clock FIFO with registered read data and status/error flags.
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   wr_en     - write request
//   wdata     - write data, sampled with wr_en
//   rd_en     - read request
//   rdata     - registered read data
//   full      - FIFO holds FIFO_DEPTH entries (combinational from pointers)
//   empty     - FIFO holds 0 entries (combinational from pointers)
//   valid     - rdata updated by a read accepted on the previous edge
//   overflow  - one-cycle pulse: write requested while full, word dropped
//   underflow - one-cycle pulse: read requested while empty
module a_fifo
  import a_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = a_fifo_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = a_fifo_pkg::FIFO_DEPTH,
  parameter int unsigned ADDR_SIZE  = a_fifo_pkg::ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  valid,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = ADDR_SIZE - 1;

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // Wrap bits differ with equal indices means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_SIZE-1] != rd_ptr[ADDR_SIZE-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      valid     <= rd_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Enables are gated with rst so a reset edge never stores or reads a word.
  a_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (rd_ok && !rst),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_a_fifo.sv
// tb_a_fifo: self-checking bench for a_fifo with a reference queue model and
// a scoreboard of expected read data.
module tb_a_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       valid;
  logic       overflow;
  logic       underflow;

  int unsigned nchk;
  int unsigned nfail;

  logic [7:0] ref_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rdata;
  logic [7:0] want;
  bit         m_rd;
  bit         m_ovf;
  bit         m_unf;

  a_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .ADDR_SIZE  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .valid     (valid),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model is updated from pre-edge occupancy and
  // accepted reads push their expected word onto the scoreboard.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit wok;
    wr_en = w;
    wdata = d;
    rd_en = r;
    m_rd  = r && (ref_q.size() != 0);
    m_unf = r && (ref_q.size() == 0);
    m_ovf = w && (ref_q.size() == 16);
    wok   = w && (ref_q.size() != 16);
    if (m_rd) exp_q.push_back(ref_q.pop_front());
    if (wok) ref_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    ref_q.delete();
    exp_q.delete();
    last_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL reset_empty: got %b want 1", empty); end
    nchk++; if (full !== 1'b0) begin nfail++; $display("FAIL reset_full: got %b want 0", full); end
    nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", valid); end
    nchk++; if (overflow !== 1'b0) begin nfail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    nchk++; if (underflow !== 1'b0) begin nfail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    nchk++; if (rdata !== 8'h00) begin nfail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
  endtask

  task automatic test_basic;
    cycle(1'b1, 8'hA5, 1'b0);
    nchk++; if (empty !== 1'b0) begin nfail++; $display("FAIL basic_empty_fall: got %b want 0", empty); end
    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      want = exp_q.pop_front();
      nchk++;
      if (valid !== 1'b1 || rdata !== want) begin
        nfail++;
        $display("FAIL basic_read%0d: valid=%b rdata=%h want valid=1 rdata=%h", i, valid, rdata, want);
      end
      last_rdata = want;
    end
    nchk++; if (rdata !== 8'h3C) begin nfail++; $display("FAIL basic_last: got %h want 3c", rdata); end
    nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL basic_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, (i == 0) ? 8'hFF : 8'(i - 1), 1'b0);
      nchk++;
      if (full !== (i == 15)) begin
        nfail++;
        $display("FAIL ovf_full_w%0d: got %b want %b", i, full, (i == 15));
      end
    end
    cycle(1'b1, 8'h0F, 1'b0);
    nchk++; if (overflow !== m_ovf || overflow !== 1'b1) begin nfail++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    nchk++; if (full !== 1'b1) begin nfail++; $display("FAIL ovf_still_full: got %b want 1", full); end
    cycle(1'b0, 8'h00, 1'b0);
    nchk++; if (overflow !== 1'b0) begin nfail++; $display("FAIL ovf_not_sticky: got %b want 0", overflow); end
  endtask

  task automatic test_underflow_wrap;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (m_rd) begin
        want = exp_q.pop_front();
        nchk++;
        if (valid !== 1'b1 || rdata !== want) begin
          nfail++;
          $display("FAIL wrap_read%0d: valid=%b rdata=%h want valid=1 rdata=%h", i, valid, rdata, want);
        end
        last_rdata = want;
      end else begin
        nchk++;
        if (valid !== 1'b0 || rdata !== last_rdata) begin
          nfail++;
          $display("FAIL unf_hold%0d: valid=%b rdata=%h want valid=0 rdata=%h", i, valid, rdata, last_rdata);
        end
      end
      nchk++;
      if (underflow !== m_unf) begin
        nfail++;
        $display("FAIL unf_flag%0d: got %b want %b", i, underflow, m_unf);
      end
      if (i == 15) begin
        nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL wrap_empty: got %b want 1", empty); end
      end
    end
    nchk++; if (rdata !== 8'h0E) begin nfail++; $display("FAIL unf_rdata_0e: got %h want 0e", rdata); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'h20 + i), 1'b1);
      want = exp_q.pop_front();
      nchk++;
      if (valid !== 1'b1 || rdata !== want || empty !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
        nfail++;
        $display("FAIL simul_rw%0d: valid=%b rdata=%h empty=%b full=%b ovf=%b want 1/%h/0/0/0",
                 i, valid, rdata, empty, full, overflow, want);
      end
      last_rdata = want;
    end
    // Occupancy must still be 4: exactly 12 more writes fill it.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b0);
      nchk++;
      if (full !== (i == 11)) begin
        nfail++;
        $display("FAIL simul_fill%0d: full=%b want %b", i, full, (i == 11));
      end
    end
    cycle(1'b1, 8'hAA, 1'b1);
    want = exp_q.pop_front();
    nchk++;
    if (valid !== 1'b1 || rdata !== want || overflow !== 1'b1) begin
      nfail++;
      $display("FAIL simul_full_rw: valid=%b rdata=%h ovf=%b want 1/%h/1", valid, rdata, overflow, want);
    end
    last_rdata = want;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      want = exp_q.pop_front();
      nchk++;
      if (valid !== 1'b1 || rdata !== want) begin
        nfail++;
        $display("FAIL simul_drain%0d: valid=%b rdata=%h want 1/%h", i, valid, rdata, want);
      end
      last_rdata = want;
    end
    nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL simul_drained: empty=%b want 1", empty); end
    cycle(1'b1, 8'h77, 1'b1);
    nchk++;
    if (underflow !== 1'b1 || valid !== 1'b0 || empty !== 1'b0 || rdata !== last_rdata) begin
      nfail++;
      $display("FAIL simul_empty_rw: unf=%b valid=%b empty=%b rdata=%h want 1/0/0/%h",
               underflow, valid, empty, rdata, last_rdata);
    end
    cycle(1'b0, 8'h00, 1'b1);
    want = exp_q.pop_front();
    nchk++;
    if (valid !== 1'b1 || rdata !== want) begin
      nfail++;
      $display("FAIL simul_no_fallthrough: valid=%b rdata=%h want 1/%h", valid, rdata, want);
    end
    last_rdata = want;
  endtask

  task automatic test_midop_reset;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    // Reset with a write request pending: reset must win.
    rst = 1'b1;
    wr_en = 1'b1;
    wdata = 8'h99;
    rd_en = 1'b1;
    ref_q.delete();
    exp_q.delete();
    last_rdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    nchk++;
    if (empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || rdata !== 8'h00) begin
      nfail++;
      $display("FAIL midrst_state: empty=%b full=%b valid=%b rdata=%h want 1/0/0/00", empty, full, valid, rdata);
    end
    cycle(1'b0, 8'h00, 1'b1);
    nchk++;
    if (underflow !== 1'b1 || valid !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_unf: unf=%b valid=%b want 1/0", underflow, valid);
    end
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'h5B, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      want = exp_q.pop_front();
      nchk++;
      if (valid !== 1'b1 || rdata !== want) begin
        nfail++;
        $display("FAIL midrst_read%0d: valid=%b rdata=%h want 1/%h", i, valid, rdata, want);
      end
    end
    nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL midrst_empty_end: got %b want 1", empty); end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow_wrap();
    test_simultaneous();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
